// File: rtl/voice_mixer.sv
// 8-voice mixer: snapshot on strobe, shared-multiplier MAC, saturate, linear stereo pan.
// Latency: strobe edge k -> LDATA/RDATA/out_valid after edge k+N_VOICES+2.
// Backpressure: none; a strobe while busy is dropped and raises the sticky overrun flag.
module voice_mixer #(
    parameter int N_VOICES  = 8,
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 7
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         sample_stb,
    input  logic [N_VOICES*SAMPLE_W-1:0] voices,
    input  logic [N_VOICES*GAIN_W-1:0]   gains,
    input  logic [14:0]                  pan,
    input  logic                         clr_ovr,
    output logic signed [SAMPLE_W-1:0]   LDATA,
    output logic signed [SAMPLE_W-1:0]   RDATA,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W  = $clog2(N_VOICES);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + IDX_W - 1;
    localparam int PAN_W  = 2 * SAMPLE_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 <<< (SAMPLE_W - 1));
    localparam logic [14:0]             PAN_MAX = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, MAC, SAT, PAN} state_t;

    state_t state_q, state_d;

    logic [N_VOICES*SAMPLE_W-1:0] v_snap;
    logic [N_VOICES*GAIN_W-1:0]   g_snap;
    logic [14:0]                  pan_snap;
    logic signed [ACC_W-1:0]      acc;
    logic [IDX_W-1:0]             idx;
    logic signed [SAMPLE_W-1:0]   mix;

    logic signed [SAMPLE_W-1:0]   v_cur;
    logic [GAIN_W-1:0]            g_cur;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      acc_shr;
    logic signed [PAN_W-1:0]      prod_l;
    logic signed [PAN_W-1:0]      prod_r;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_stb) state_d = MAC;
            MAC:     if (idx == IDX_W'(N_VOICES - 1)) state_d = SAT;
            SAT:     state_d = PAN;
            PAN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    assign busy = (state_q != IDLE);

    // One shared multiplier: the gain is zero-extended so it stays non-negative as a signed operand.
    assign v_cur   = v_snap[int'(idx)*SAMPLE_W +: SAMPLE_W];
    assign g_cur   = g_snap[int'(idx)*GAIN_W +: GAIN_W];
    assign prod    = v_cur * $signed({1'b0, g_cur});
    assign acc_shr = acc >>> GAIN_FRAC;
    assign prod_l  = mix * $signed({1'b0, PAN_MAX - pan_snap});
    assign prod_r  = mix * $signed({1'b0, pan_snap});

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v_snap    <= '0;
            g_snap    <= '0;
            pan_snap  <= '0;
            acc       <= '0;
            idx       <= '0;
            mix       <= '0;
            LDATA     <= '0;
            RDATA     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_stb) begin
                        v_snap   <= voices;
                        g_snap   <= gains;
                        pan_snap <= pan;
                        acc      <= '0;
                        idx      <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                    idx <= idx + 1'b1;
                end
                SAT: begin
                    if (acc_shr > SAT_MAX)      mix <= SAT_MAX[SAMPLE_W-1:0];
                    else if (acc_shr < SAT_MIN) mix <= SAT_MIN[SAMPLE_W-1:0];
                    else                        mix <= acc_shr[SAMPLE_W-1:0];
                end
                PAN: begin
                    // Taking bits [30:15] is the arithmetic >>>15; the result always fits the sample width.
                    LDATA     <= prod_l[SAMPLE_W+14:15];
                    RDATA     <= prod_r[SAMPLE_W+14:15];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A fresh overrun beats a simultaneous clear.
    always_ff @(posedge Clk) begin
        if (!Reset_n)                  overrun <= 1'b0;
        else if (sample_stb && busy)   overrun <= 1'b1;
        else if (clr_ovr)              overrun <= 1'b0;
    end

endmodule
